// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain streamer and its skid buffer.
package fifo_drain_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_LEN_W      = 8;
    localparam int SKID_DEPTH     = 2;
    localparam int SKID_PTR_W     = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W     = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry skid buffer: absorbs words already in flight from the FIFO while the sink stalls.
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  head_valid,
    output logic [SKID_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      entry_data [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_reg;
    logic [SKID_PTR_W-1:0] rd_ptr_reg;
    logic [SKID_CNT_W-1:0] count_reg;
    logic [SKID_CNT_W-1:0] count_next;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count_reg != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count_reg != SKID_CNT_W'(SKID_DEPTH)) || do_pop);

    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_reg <= '0;
            end else if (do_push && (wr_ptr_reg == SKID_PTR_W'(gi))) begin
                data_reg <= push_data;
            end
        end

        assign entry_data[gi] = data_reg;
    end

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign head_data  = entry_data[rd_ptr_reg];
    assign head_valid = (count_reg != '0);
    assign count      = count_reg;

endmodule

// File: rtl/fifo_drain_streamer.sv
// Drains burst_len words from a 1-cycle-latency FIFO read port onto a valid/ready stream.
module fifo_drain_streamer
    import fifo_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_underflow,
    output logic [LEN_W-1:0]      sent_count
);

    state_t                state_reg;
    state_t                state_next;
    logic [LEN_W-1:0]      len_reg;
    logic [LEN_W-1:0]      len_next;
    logic [LEN_W-1:0]      issued_reg;
    logic [LEN_W-1:0]      issued_next;
    logic [LEN_W-1:0]      sent_reg;
    logic [LEN_W-1:0]      sent_next;
    logic                  inflight_reg;
    logic                  err_reg;
    logic                  err_next;
    logic [SKID_CNT_W-1:0] buf_cnt;
    logic [SKID_CNT_W:0]   outstanding;
    logic                  pop;
    logic                  push;
    logic                  uf_hit;
    logic                  accept_start;

    assign pop          = m_valid & m_ready;
    assign push         = inflight_reg & ~fifo_underflow;
    assign uf_hit       = inflight_reg & fifo_underflow;
    assign accept_start = (state_reg == IDLE) & start;

    // Words buffered plus the one in flight, after this cycle's pop, must leave a free slot.
    assign outstanding = {1'b0, buf_cnt} + (SKID_CNT_W+1)'(inflight_reg) - (SKID_CNT_W+1)'(pop);
    assign fifo_rd_en  = (state_reg == RUN) & ~fifo_empty & (issued_reg < len_reg)
                       & (outstanding < (SKID_CNT_W+1)'(SKID_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // An underflowed final word rolls issued back, so stay to re-request it.
                if ((issued_reg == len_reg) && !uf_hit) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((buf_cnt == '0) && !inflight_reg) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN) || (state_reg == DRAIN);
        done = (state_reg == DONE);
    end

    always_comb begin
        len_next    = accept_start ? burst_len : len_reg;
        issued_next = issued_reg + LEN_W'(fifo_rd_en) - LEN_W'(uf_hit);
        sent_next   = sent_reg;
        err_next    = err_reg | uf_hit;
        if (pop && (sent_reg != len_reg)) begin
            sent_next = sent_reg + 1'b1;
        end
        if (accept_start) begin
            issued_next = '0;
            sent_next   = '0;
            err_next    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg      <= '0;
            issued_reg   <= '0;
            sent_reg     <= '0;
            inflight_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            len_reg      <= len_next;
            issued_reg   <= issued_next;
            sent_reg     <= sent_next;
            inflight_reg <= fifo_rd_en;
            err_reg      <= err_next;
        end
    end

    fifo_drain_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (fifo_data_out),
        .pop        (pop),
        .head_data  (m_data),
        .head_valid (m_valid),
        .count      (buf_cnt)
    );

    assign err_underflow = err_reg;
    assign sent_count    = sent_reg;

endmodule
